// File: rtl/prbs_chk_pkg.sv
// Shared types, constants and PRBS-15 helpers for the PRBS lock checker.
// popcount8 is only referenced when PRBS_CHK_BITERR_EN is defined.
package prbs_chk_pkg;

    localparam int PRBS_LEN = 15;
    localparam int TAP_A    = 14;
    localparam int TAP_B    = 13;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEED0  = 3'd1,
        ST_SEED1  = 3'd2,
        ST_HUNT   = 3'd3,
        ST_LOCKED = 3'd4
    } chk_state_t;

    typedef struct packed {
        logic [7:0]          pred;
        logic [PRBS_LEN-1:0] nxt;
    } prbs_step_t;

    // Eight LFSR steps; the first generated bit lands in pred[7].
    function automatic prbs_step_t prbs15_next8(input logic [PRBS_LEN-1:0] s);
        prbs_step_t          r;
        logic [PRBS_LEN-1:0] v;
        logic                b;
        v      = s;
        r.pred = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            b         = v[TAP_A] ^ v[TAP_B];
            r.pred[i] = b;
            v         = {v[PRBS_LEN-2:0], b};
        end
        r.nxt = v;
        return r;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, d[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/prbs_chk_lfsr8.sv
// PRBS-15 reference register: byte-wise seed shift or 8-step advance,
// with the predicted byte derived combinationally from the current state.
module prbs15_lfsr8
    import prbs_chk_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load_byte,
    input  logic       i_advance,
    input  logic [7:0] i_data,
    output logic [7:0] o_pred
);

    logic [PRBS_LEN-1:0] r_s;
    prbs_step_t          w_step;

    // Prediction for the byte currently on the input.
    always_comb begin
        w_step = prbs15_next8(r_s);
    end

    assign o_pred = w_step.pred;

    // Seed shift keeps the most recent 15 received bits; advance jumps 8 steps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s <= {PRBS_LEN{1'b0}};
        end else if (i_load_byte) begin
            r_s <= {r_s[6:0], i_data};
        end else if (i_advance) begin
            r_s <= w_step.nxt;
        end else begin
            r_s <= r_s;
        end
    end

endmodule

// File: rtl/prbs_lock_checker.sv
// PRBS-15 lock checker: self-seeds after the preamble flag, hunts for lock,
// then counts errors and bytes. Define PRBS_CHK_BITERR_EN to count bit errors.
module prbs_lock_checker
    import prbs_chk_pkg::*;
#(
    parameter int LOCK_BYTES  = 16,
    parameter int UNLOCK_ERRS = 4
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [7:0]  in,
    input  logic        in_valid,
    input  logic        pattern_detected,
    input  logic        clr,
    output logic        locked,
    output logic [15:0] err_count,
    output logic [31:0] byte_count
);

    localparam logic [7:0] LP_LOCK_LAST   = 8'(LOCK_BYTES - 1);
    localparam logic [7:0] LP_UNLOCK_LAST = 8'(UNLOCK_ERRS - 1);

    chk_state_t  r_state;
    chk_state_t  w_state_nxt;
    logic [7:0]  r_hit_cnt;
    logic [7:0]  w_hit_nxt;
    logic [7:0]  r_miss_cnt;
    logic [7:0]  w_miss_nxt;
    logic        r_locked;
    logic [15:0] r_err_count;
    logic [31:0] r_byte_count;
    logic        w_load;
    logic        w_advance;
    logic [7:0]  w_pred;
    logic        w_match;
    logic [15:0] w_err_inc;
    logic [16:0] w_err_sum;
    logic        w_count_en;

    prbs15_lfsr8 u_lfsr (
        .i_clk       (CLK),
        .i_rst_n     (RSTn),
        .i_load_byte (w_load),
        .i_advance   (w_advance),
        .i_data      (in),
        .o_pred      (w_pred)
    );

    assign w_match    = (in == w_pred);
    assign w_count_en = in_valid && (r_state == ST_LOCKED);

    // Next-state, hit/miss run lengths and LFSR controls.
    always_comb begin
        w_state_nxt = r_state;
        w_hit_nxt   = r_hit_cnt;
        w_miss_nxt  = r_miss_cnt;
        w_load      = 1'b0;
        w_advance   = 1'b0;
        if (in_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (pattern_detected) begin
                        w_state_nxt = ST_SEED0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_SEED0: begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SEED1;
                end
                ST_SEED1: begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_HUNT;
                end
                ST_HUNT: begin
                    w_advance = 1'b1;
                    if (!w_match) begin
                        w_hit_nxt   = 8'd0;
                        w_state_nxt = ST_SEED0;
                    end else if (r_hit_cnt == LP_LOCK_LAST) begin
                        w_hit_nxt   = 8'd0;
                        w_state_nxt = ST_LOCKED;
                    end else begin
                        w_hit_nxt = r_hit_cnt + 8'd1;
                    end
                end
                ST_LOCKED: begin
                    w_advance = 1'b1;
                    if (w_match) begin
                        w_miss_nxt = 8'd0;
                    end else if (r_miss_cnt == LP_UNLOCK_LAST) begin
                        w_miss_nxt  = 8'd0;
                        w_state_nxt = ST_SEED0;
                    end else begin
                        w_miss_nxt = r_miss_cnt + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Error increment for the current byte and its saturating sum.
    always_comb begin
`ifdef PRBS_CHK_BITERR_EN
        w_err_inc = {12'd0, popcount8(in ^ w_pred)};
`else
        w_err_inc = w_match ? 16'd0 : 16'd1;
`endif
        w_err_sum = {1'b0, r_err_count} + {1'b0, w_err_inc};
    end

    // State, run-length counters and the registered lock flag.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= ST_IDLE;
            r_hit_cnt  <= 8'd0;
            r_miss_cnt <= 8'd0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hit_cnt  <= w_hit_nxt;
            r_miss_cnt <= w_miss_nxt;
            r_locked   <= (w_state_nxt == ST_LOCKED);
        end
    end

    // Link-quality counters: clear has priority, both saturate and hold outside LOCKED.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_err_count  <= 16'd0;
            r_byte_count <= 32'd0;
        end else if (clr) begin
            r_err_count  <= 16'd0;
            r_byte_count <= 32'd0;
        end else if (w_count_en) begin
            r_err_count  <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
            if (r_byte_count != 32'hFFFF_FFFF) begin
                r_byte_count <= r_byte_count + 32'd1;
            end else begin
                r_byte_count <= r_byte_count;
            end
        end else begin
            r_err_count  <= r_err_count;
            r_byte_count <= r_byte_count;
        end
    end

    assign locked     = r_locked;
    assign err_count  = r_err_count;
    assign byte_count = r_byte_count;

endmodule

// File: doc/prbs_lock_checker.md
# prbs_lock_checker

Downstream consumer of the PRBS byte stream and the pattern-detector flag. After the detector reports the preamble, the block self-seeds a PRBS-15 reference LFSR from the incoming bytes. It then hunts for lock and, once locked, counts byte errors and received bytes for link-quality reporting. It sits at the receive end of the generator/detector pair and exposes only status and counters.

## Interface
Parameters:
- LOCK_BYTES, 16: consecutive matching bytes in HUNT required to declare lock (1..255).
- UNLOCK_ERRS, 4: consecutive mismatching bytes in LOCKED that drop lock (1..255).

Ports:
- CLK  input  1  single clock, all logic rising-edge.
- RSTn  input  1  asynchronous, active-low reset.
- in  input  8  received byte; bit 7 is the first bit in time.
- in_valid  input  1  qualifies `in`; tie high for a continuous stream.
- pattern_detected  input  1  preamble-found flag from the pattern detector.
- clr  input  1  synchronous clear of counters.
- locked  output  1  checker is in LOCKED.
- err_count  output  16  saturating error count while LOCKED.
- byte_count  output  32  saturating count of valid bytes received while LOCKED.

## Operation
- LFSR: 15-bit state s, polynomial x^15+x^14+1.
  - Per bit: b = s[14]^s[13]; s = {s[13:0], b}.
  - Predicted byte = 8 successive b, first b in bit 7.
- States: IDLE, SEED0, SEED1, HUNT, LOCKED. Only valid cycles advance SEED/HUNT/LOCKED logic.
- IDLE: on pattern_detected=1 go to SEED0. The byte in that same cycle is ignored.
- SEED0/SEED1: s <= {s[6:0], in}. After SEED1, s holds the last 15 received bits. SEED0->SEED1->HUNT.
- HUNT:
  - Compare in to the predicted byte and advance s to the predicted state.
  - On match, hit_cnt++. When hit_cnt reaches LOCK_BYTES, go to LOCKED and clear hit_cnt.
  - On mismatch, clear hit_cnt and go to SEED0 (reseed).
- LOCKED:
  - s free-runs on its own prediction; data never reloads it.
  - Each valid byte increments byte_count.
  - A mismatch increments err_count and miss_cnt; a match clears miss_cnt.
  - When miss_cnt reaches UNLOCK_ERRS, go to SEED0 and clear miss_cnt.
- pattern_detected is ignored outside IDLE.
- Counters:
  - Both saturate at all-ones.
  - Neither changes outside LOCKED; both hold their values across lock loss.
- clr=1: both counters become 0 next cycle. clr wins over a simultaneous increment. State and LFSR are unaffected.

## Timing
- Reset: state=IDLE, s=0, hit_cnt=miss_cnt=0, locked=0, err_count=0, byte_count=0.
- All outputs are registered.
  - locked rises the cycle after the LOCK_BYTES-th matching byte is sampled.
  - locked falls the cycle after the UNLOCK_ERRS-th consecutive mismatch is sampled.
- Counters update the cycle after the sampled byte.
  - The byte that completes lock is not counted in byte_count.
  - The byte that drops lock is counted in both counters.
- in_valid=0: no state, LFSR or counter change.
- RSTn asserted mid-operation returns everything to reset values immediately (asynchronous).

## Configuration
- PRBS_CHK_BITERR_EN defined: err_count adds the popcount of (in ^ predicted), 0..8 per byte. The add saturates and lock logic is unchanged.
- Not defined: err_count adds 1 per mismatching byte.

## Structure
- Package prbs_chk_pkg holds:
  - the state enum chk_state_t;
  - constants PRBS_LEN=15, TAP_A=14, TAP_B=13;
  - function prbs15_next8(s) returning the predicted byte and next state;
  - function popcount8 (used under the macro).
- Sub-module prbs15_lfsr8: 15-bit register with `load_byte` (seed shift) and `advance` (8-step) controls. It outputs the predicted byte combinationally from the current state.

## Test plan
- Reset: assert RSTn=0 mid-stream -> locked=0, err_count=0, byte_count=0 immediately.
- Clean lock: pattern_detected pulse, then a continuous PRBS-15 stream seeded 15'h0001 -> locked rises at the 18th valid byte after the pulse (2 seed + 16 hunt). byte_count then increments once per byte.
- Single error: flip bit 0 of one byte while LOCKED -> err_count=1 (or 1 with the macro). locked stays 1 and the following bytes show no extra errors.
- Lock loss: 4 consecutive corrupted bytes while LOCKED -> err_count=4, locked falls after the 4th. Clean stream resumes -> relock after 18 more bytes.
- Hunt failure: corrupt the 5th hunt byte -> reseed occurs and locked rises 18 bytes after the corrupted byte.
- Saturation/clr/valid: preload near saturation via long errored run with macro, bytes 8'hFF vs predicted inverse -> err_count sticks at 16'hFFFF. Assert clr together with an error -> 0. With in_valid=0 gaps, the counters hold.
